sr_strobe_gen: RTL and testbench
================================

Name: sr_strobe_gen

Overview:
- Upstream driver for the NAND set/reset latch (active-low s, r inputs).
- Takes two raw asynchronous push-button inputs and synchronises and debounces each one.
- Converts each debounced rising edge into a fixed-width active-low strobe on s or r.
- Arbitrates so the latch never sees s and r low together (the forbidden NAND-latch state).

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required before the debounced level changes (min 2).
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- PULSE_LEN, 4: cycles each strobe is held low (min 1).
- RESET_PRIORITY, 1: 1 = reset request wins a same-cycle tie; 0 = set wins.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- btn_set  in  1  raw, asynchronous, bouncing set button
- btn_reset  in  1  raw, asynchronous, bouncing reset button
- s  out  1  active-low set strobe to latch, registered
- r  out  1  active-low reset strobe to latch, registered
- db_set  out  1  debounced btn_set level
- db_reset  out  1  debounced btn_reset level
- busy  out  1  high while state != IDLE
- overrun  out  1  one-cycle flag: a request was dropped

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; rst sampled high forces all state at the next edge, regardless of any pulse in progress.
- Reset values: s=1, r=1, db_set=0, db_reset=0, busy=0, overrun=0, sync flops 0, counters 0, pending flags 0, state IDLE.
- Synchroniser: two flops per button, so the synchronised level lags the raw input by 2 edges.
- Debounce, per channel:
  - Counter clears whenever synchronised level == db level.
  - Counter increments while they differ.
  - When it differs with count == DEBOUNCE_CYCLES-1, db toggles at that edge and the counter clears.
  - Net effect: db changes DEBOUNCE_CYCLES edges after the synchronised level first differs.
  - Any glitch shorter than that leaves db unchanged.
- Edge detect: req = db & ~db_q, where db_q is db delayed one cycle. Falling edges produce nothing.
- Pending flags: one 1-deep flag per channel (pend_s, pend_r), set by req and cleared when its strobe starts.
  - If req arrives while the same channel's flag is already set, drop the request and pulse overrun=1 for one cycle.
- FSM states: IDLE, SET_PULSE, RST_PULSE, GAP.
  - IDLE -> SET_PULSE when pend_s (or a same-cycle set req) and no reset wins; -> RST_PULSE symmetrically.
  - With both pending, RESET_PRIORITY picks the winner; the loser stays pending.
  - SET_PULSE / RST_PULSE last exactly PULSE_LEN cycles, then -> GAP.
  - GAP lasts exactly 1 cycle with s=r=1, then -> IDLE.
  - Requests arriving during a pulse or GAP are latched in pending flags and served from IDLE afterwards.
- Strobe outputs: s=0 exactly during SET_PULSE cycles, r=0 exactly during RST_PULSE cycles. First low cycle is the cycle after the state is entered from IDLE.
  - Latency: db rising edge -> strobe low 1 cycle later when IDLE.
- Invariant: s|r == 1 in every cycle, including reset entry and exit.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: SR_STROBE_TRACK_EN.
- Defined:
  - Adds output q_track (1 bit, reset 0): set to 1 at the end of each SET_PULSE and to 0 at the end of each RST_PULSE, mirroring the latch q.
  - A request matching the current q_track value (set while q_track=1, reset while q_track=0) is discarded silently: no strobe, no overrun.
- Not defined: no q_track port, and every accepted request produces a strobe.

Test Plan:
- Reset: hold rst 3 cycles with buttons toggling -> s=1, r=1, busy=0, db_*=0 throughout and on release.
- Clean set (DEBOUNCE_CYCLES=4, PULSE_LEN=3): btn_set 0->1 and held -> db_set rises 6 edges after raw change; s low for exactly 3 cycles starting 1 cycle later; then 1 GAP cycle; busy high across all 4.
- Bounce: btn_set toggles with high intervals of 1-3 cycles, then settles high -> exactly one s strobe; db_set never glitches.
- Tie: both buttons rise in the same cycle, RESET_PRIORITY=1 -> r low 3 cycles, 1 GAP cycle, then s low 3 cycles; s and r never both 0.
- Overrun: second set edge while pend_s is set (during an r pulse) -> overrun=1 for 1 cycle, only one s strobe.
- Mid-pulse reset: assert rst in the 2nd cycle of SET_PULSE -> s=1 at the next edge, state IDLE, pending cleared; with SR_STROBE_TRACK_EN, q_track=0.

Source files
------------

// File: rtl/sr_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : sr_strobe_gen
// Description : Synchronises and debounces two raw push-buttons and turns each
//               debounced press into a fixed-width active-low strobe on s (set)
//               or r (reset) for a NAND set/reset latch. Arbitration guarantees
//               s and r are never low in the same cycle.
// Options     : define SR_STROBE_TRACK_EN to add the q_track output and to
//               silently discard requests that would not change the latch.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_strobe_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int PULSE_LEN       = 4,
    parameter int RESET_PRIORITY  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic s,
    output logic r,
    output logic db_set,
    output logic db_reset,
    output logic busy,
    output logic overrun
`ifdef SR_STROBE_TRACK_EN
    ,
    output logic q_track
`endif
);

    localparam int C_PULSE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int C_CH_SET  = 0;
    localparam int C_CH_RST  = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0] w_btn;
    logic [1:0] w_db;
    logic [1:0] w_req;

    assign w_btn = {btn_reset, btn_set};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_q;
            logic             sync2_q;
            logic             db_q;
            logic             db_d;
            logic             db_dly_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Debounce: count cycles the synchronised level disagrees, flip once the window is full
            always_comb begin
                db_d  = db_q;
                cnt_d = '0;
                if (sync2_q != db_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_d = ~db_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // Two-flop synchroniser, debounced level and its delayed copy for edge detection
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    db_q     <= 1'b0;
                    db_dly_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q  <= w_btn[gi];
                    sync2_q  <= sync1_q;
                    db_q     <= db_d;
                    db_dly_q <= db_q;
                    cnt_q    <= cnt_d;
                end
            end

            assign w_db[gi]  = db_q;
            assign w_req[gi] = db_q & ~db_dly_q;
        end
    endgenerate

    state_t               state_q;
    state_t               state_d;
    logic [C_PULSE_W-1:0] pulse_cnt_q;
    logic [C_PULSE_W-1:0] pulse_cnt_d;
    logic                 pend_s_q;
    logic                 pend_s_d;
    logic                 pend_r_q;
    logic                 pend_r_d;
    logic                 s_q;
    logic                 s_d;
    logic                 r_q;
    logic                 r_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 w_acc_s;
    logic                 w_acc_r;
`ifdef SR_STROBE_TRACK_EN
    logic                 q_track_q;
    logic                 q_track_d;
`endif

    // Request acceptance, pending flags, arbitration and next-state / output decode
    always_comb begin
        w_acc_s = w_req[C_CH_SET];
        w_acc_r = w_req[C_CH_RST];
`ifdef SR_STROBE_TRACK_EN
        // A request that would leave the latch unchanged is dropped without a flag.
        q_track_d = q_track_q;
        w_acc_s   = w_req[C_CH_SET] & ~q_track_q;
        w_acc_r   = w_req[C_CH_RST] & q_track_q;
`endif
        // Flags are one deep: a second request on an occupied flag is lost.
        overrun_d   = (w_acc_s & pend_s_q) | (w_acc_r & pend_r_q);
        pend_s_d    = pend_s_q | w_acc_s;
        pend_r_d    = pend_r_q | w_acc_r;
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            IDLE: begin
                pulse_cnt_d = '0;
                if (pend_r_d && ((RESET_PRIORITY != 0) || !pend_s_d)) begin
                    state_d  = RST_PULSE;
                    pend_r_d = 1'b0;
                end else if (pend_s_d) begin
                    state_d  = SET_PULSE;
                    pend_s_d = 1'b0;
                end
            end
            SET_PULSE: begin
                if (pulse_cnt_q == C_PULSE_W'(PULSE_LEN - 1)) begin
                    state_d = GAP;
`ifdef SR_STROBE_TRACK_EN
                    q_track_d = 1'b1;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + C_PULSE_W'(1);
                end
            end
            RST_PULSE: begin
                if (pulse_cnt_q == C_PULSE_W'(PULSE_LEN - 1)) begin
                    state_d = GAP;
`ifdef SR_STROBE_TRACK_EN
                    q_track_d = 1'b0;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + C_PULSE_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        s_d    = (state_d != SET_PULSE);
        r_d    = (state_d != RST_PULSE);
        busy_d = (state_d != IDLE);
    end

    // Strobe FSM with registered outputs; reset forces both strobes high immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            pend_s_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            s_q         <= 1'b1;
            r_q         <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SR_STROBE_TRACK_EN
            q_track_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            pend_s_q    <= pend_s_d;
            pend_r_q    <= pend_r_d;
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef SR_STROBE_TRACK_EN
            q_track_q   <= q_track_d;
`endif
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign db_set   = w_db[C_CH_SET];
    assign db_reset = w_db[C_CH_RST];
    assign busy     = busy_q;
    assign overrun  = overrun_q;
`ifdef SR_STROBE_TRACK_EN
    assign q_track  = q_track_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_strobe_gen
// Description : Self-checking bench for sr_strobe_gen. Directed scenarios use
//               constant expectations; a randomized run is compared cycle by
//               cycle against a behavioural model of the button-to-strobe path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_strobe_gen;

    localparam int DB_CYC     = 4;
    localparam int PULSE      = 3;
    localparam int PRIO       = 1;
    localparam int PULSE_LONG = 12;

    logic clk = 1'b0;
    logic rst;
    logic btn_set;
    logic btn_reset;
    logic s, r, db_set, db_reset, busy, overrun;
    logic s2, r2, db_set2, db_reset2, busy2, overrun2;
`ifdef SR_STROBE_TRACK_EN
    logic q_track, q_track2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_strobe_gen #(
        .DEBOUNCE_CYCLES (DB_CYC),
        .CNT_W           (8),
        .PULSE_LEN       (PULSE),
        .RESET_PRIORITY  (PRIO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .s         (s),
        .r         (r),
        .db_set    (db_set),
        .db_reset  (db_reset),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SR_STROBE_TRACK_EN
        ,
        .q_track   (q_track)
`endif
    );

    // Long-pulse instance: gives a wide enough window to land a second press on a full flag.
    sr_strobe_gen #(
        .DEBOUNCE_CYCLES (DB_CYC),
        .CNT_W           (8),
        .PULSE_LEN       (PULSE_LONG),
        .RESET_PRIORITY  (PRIO)
    ) u_dut_long (
        .clk       (clk),
        .rst       (rst),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .s         (s2),
        .r         (r2),
        .db_set    (db_set2),
        .db_reset  (db_reset2),
        .busy      (busy2),
        .overrun   (overrun2)
`ifdef SR_STROBE_TRACK_EN
        ,
        .q_track   (q_track2)
`endif
    );

    // ---------------- behavioural model of u_dut ----------------
    logic [1:0] m_sync1 = '0, m_sync2 = '0, m_db = '0, m_db_prev = '0, m_pend = '0;
    int         m_run [2];
    int         m_left = 0;   // busy cycles still to come: pulse cycles then one gap
    int         m_kind = 0;   // 0 = set strobe, 1 = reset strobe
    logic       m_ovr = 1'b0;
    logic       m_qt  = 1'b0;
    logic       m_s = 1'b1, m_r = 1'b1, m_busy = 1'b0;

    task automatic model_edge(input logic bs, input logic br, input logic rs);
        logic [1:0] raw;
        logic [1:0] req;
        logic [1:0] acc;
        raw = {br, bs};
        if (rs) begin
            m_sync1 = '0; m_sync2 = '0; m_db = '0; m_db_prev = '0; m_pend = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_left = 0; m_kind = 0; m_ovr = 1'b0; m_qt = 1'b0;
        end else begin
            req = m_db & ~m_db_prev;
            m_db_prev = m_db;
            for (int c = 0; c < 2; c++) begin
                if (m_sync2[c] != m_db[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DB_CYC) begin
                        m_db[c]  = ~m_db[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = raw;

            acc = req;
`ifdef SR_STROBE_TRACK_EN
            acc[0] = req[0] & ~m_qt;
            acc[1] = req[1] & m_qt;
`endif
            m_ovr = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (acc[c]) begin
                    if (m_pend[c]) m_ovr = 1'b1;
                    else           m_pend[c] = 1'b1;
                end
            end
            if (m_left > 0) begin
                if (m_left == 2) m_qt = (m_kind == 0);
                m_left = m_left - 1;
            end else if (m_pend[1] && (PRIO != 0 || !m_pend[0])) begin
                m_kind = 1; m_pend[1] = 1'b0; m_left = PULSE + 1;
            end else if (m_pend[0]) begin
                m_kind = 0; m_pend[0] = 1'b0; m_left = PULSE + 1;
            end
        end
        m_s    = !(m_left >= 2 && m_kind == 0);
        m_r    = !(m_left >= 2 && m_kind == 1);
        m_busy = (m_left > 0);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then settle before sampling.
    task automatic step(input logic bs, input logic br, input logic rs);
        btn_set   = bs;
        btn_reset = br;
        rst       = rs;
        @(posedge clk);
        model_edge(bs, br, rs);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(i[0], ~i[0], 1'b1);
            else       step(1'b0, 1'b0, 1'b0);
            checks++; if (s !== 1'b1)        begin errors++; $display("FAIL reset_s cyc %0d: got %b want 1", i, s); end
            checks++; if (r !== 1'b1)        begin errors++; $display("FAIL reset_r cyc %0d: got %b want 1", i, r); end
            checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
            checks++; if (db_set !== 1'b0)   begin errors++; $display("FAIL reset_db_set cyc %0d: got %b want 0", i, db_set); end
            checks++; if (db_reset !== 1'b0) begin errors++; $display("FAIL reset_db_reset cyc %0d: got %b want 0", i, db_reset); end
            checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun cyc %0d: got %b want 0", i, overrun); end
        end
    endtask

    task automatic test_clean_set();
        int db_first = 0, s_first = 0, s_cnt = 0, s_last = 0, busy_first = 0, busy_cnt = 0, r_cnt = 0, ovr_cnt = 0;
        settle(30);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (db_set === 1'b1 && db_first == 0) db_first = i;
            if (s === 1'b0) begin if (s_first == 0) s_first = i; s_cnt++; s_last = i; end
            if (busy === 1'b1) begin if (busy_first == 0) busy_first = i; busy_cnt++; end
            if (r === 1'b0) r_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
        end
        checks++; if (db_first != 6)   begin errors++; $display("FAIL clean_db_rise: got %0d want 6", db_first); end
        checks++; if (s_first != 7)    begin errors++; $display("FAIL clean_s_first: got %0d want 7", s_first); end
        checks++; if (s_cnt != PULSE || s_last != 6 + PULSE)
                                        begin errors++; $display("FAIL clean_s_len: got %0d (last %0d) want %0d", s_cnt, s_last, PULSE); end
        checks++; if (busy_first != 7 || busy_cnt != PULSE + 1)
                                        begin errors++; $display("FAIL clean_busy: got first %0d cnt %0d want 7 %0d", busy_first, busy_cnt, PULSE + 1); end
        checks++; if (r_cnt != 0)      begin errors++; $display("FAIL clean_r_quiet: got %0d want 0", r_cnt); end
        checks++; if (ovr_cnt != 0)    begin errors++; $display("FAIL clean_overrun: got %0d want 0", ovr_cnt); end
        s_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (s === 1'b0) s_cnt++;
        end
        checks++; if (s_cnt != 0 || db_set !== 1'b0)
                                        begin errors++; $display("FAIL clean_release: got s_low %0d db %b want 0 0", s_cnt, db_set); end
    endtask

    task automatic test_bounce();
        int strobes = 0, rises = 0, falls = 0;
        logic prev_s, prev_db;
        settle(30);
        prev_s = s; prev_db = db_set;
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 2; j++) begin
                int len;
                len = int'($urandom_range(1, 3));
                for (int t = 0; t < len; t++) begin
                    step(j == 0, 1'b0, 1'b0);
                    if (prev_s === 1'b1 && s === 1'b0) strobes++;
                    if (prev_db === 1'b0 && db_set === 1'b1) rises++;
                    if (prev_db === 1'b1 && db_set === 1'b0) falls++;
                    prev_s = s; prev_db = db_set;
                end
            end
        end
        for (int t = 0; t < 25; t++) begin
            step(1'b1, 1'b0, 1'b0);
            if (prev_s === 1'b1 && s === 1'b0) strobes++;
            if (prev_db === 1'b0 && db_set === 1'b1) rises++;
            if (prev_db === 1'b1 && db_set === 1'b0) falls++;
            prev_s = s; prev_db = db_set;
        end
        checks++; if (strobes != 1) begin errors++; $display("FAIL bounce_strobes: got %0d want 1", strobes); end
        checks++; if (rises != 1 || falls != 0)
                                     begin errors++; $display("FAIL bounce_db: got rises %0d falls %0d want 1 0", rises, falls); end
    endtask

    task automatic test_tie();
        int r_first = 0, r_cnt = 0, s_first = 0, s_cnt = 0, both = 0;
        settle(30);
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (r === 1'b0) begin if (r_first == 0) r_first = i; r_cnt++; end
            if (s === 1'b0) begin if (s_first == 0) s_first = i; s_cnt++; end
            if (s === 1'b0 && r === 1'b0) both++;
        end
        checks++; if (r_first != 7 || r_cnt != PULSE)
                                 begin errors++; $display("FAIL tie_r: got first %0d cnt %0d want 7 %0d", r_first, r_cnt, PULSE); end
        checks++; if (s_first != 12 || s_cnt != PULSE)
                                 begin errors++; $display("FAIL tie_s: got first %0d cnt %0d want 12 %0d", s_first, s_cnt, PULSE); end
        checks++; if (both != 0) begin errors++; $display("FAIL tie_both_low: got %0d want 0", both); end
    endtask

    task automatic test_overrun();
        int ovr_cnt = 0, ovr_at = 0, s2_str = 0, r2_str = 0, s_str = 0, ovr_main = 0;
        logic prev_s2, prev_r2, prev_s;
        settle(30);
        prev_s2 = s2; prev_r2 = r2; prev_s = s;
        for (int i = 1; i <= 60; i++) begin
            step((i >= 4 && i <= 7) || (i >= 12 && i <= 35), i <= 10, 1'b0);
            if (overrun2 === 1'b1) begin ovr_cnt++; if (ovr_at == 0) ovr_at = i; end
            if (overrun === 1'b1) ovr_main++;
            if (prev_s2 === 1'b1 && s2 === 1'b0) s2_str++;
            if (prev_r2 === 1'b1 && r2 === 1'b0) r2_str++;
            if (prev_s === 1'b1 && s === 1'b0) s_str++;
            prev_s2 = s2; prev_r2 = r2; prev_s = s;
        end
        checks++; if (ovr_cnt != 1 || ovr_at != 18)
                                   begin errors++; $display("FAIL ovr_flag: got cnt %0d at %0d want 1 at 18", ovr_cnt, ovr_at); end
        checks++; if (s2_str != 1) begin errors++; $display("FAIL ovr_s_strobes: got %0d want 1", s2_str); end
        checks++; if (r2_str != 1) begin errors++; $display("FAIL ovr_r_strobes: got %0d want 1", r2_str); end
        checks++; if (s_str != 2 || ovr_main != 0)
                                   begin errors++; $display("FAIL ovr_short_inst: got s %0d ovr %0d want 2 0", s_str, ovr_main); end
    endtask

    task automatic test_mid_pulse_reset();
        int seen = 0, s_cnt = 0, busy_cnt = 0;
        settle(30);
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (s === 1'b0) seen = 1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL midrst_start: got no strobe want strobe"); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL midrst_2nd_cycle: got s %b want 0", s); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (s !== 1'b1 || r !== 1'b1 || busy !== 1'b0 || db_set !== 1'b0)
            begin errors++; $display("FAIL midrst_after: got s %b r %b busy %b db %b want 1 1 0 0", s, r, busy, db_set); end
`ifdef SR_STROBE_TRACK_EN
        checks++; if (q_track !== 1'b0) begin errors++; $display("FAIL midrst_qtrack: got %b want 0", q_track); end
`endif
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (s === 1'b0) s_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (s_cnt != 0 || busy_cnt != 0)
            begin errors++; $display("FAIL midrst_pending: got s_low %0d busy %0d want 0 0", s_cnt, busy_cnt); end
    endtask

    task automatic test_random();
        logic bs, br, rs;
        int hold_s, hold_r;
        bs = 1'b0; br = 1'b0; hold_s = 3; hold_r = 11;
        for (int n = 0; n < 3000; n++) begin
            if (hold_s == 0) begin
                bs = ~bs;
                hold_s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 20));
            end else hold_s--;
            if (hold_r == 0) begin
                br = ~br;
                hold_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 20));
            end else hold_r--;
            rs = ($urandom_range(0, 399) == 0);
            step(bs, br, rs);
            checks++; if (s !== m_s)           begin errors++; $display("FAIL rand_s cyc %0d: got %b want %b", n, s, m_s); end
            checks++; if (r !== m_r)           begin errors++; $display("FAIL rand_r cyc %0d: got %b want %b", n, r, m_r); end
            checks++; if (busy !== m_busy)     begin errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", n, busy, m_busy); end
            checks++; if (overrun !== m_ovr)   begin errors++; $display("FAIL rand_overrun cyc %0d: got %b want %b", n, overrun, m_ovr); end
            checks++; if (db_set !== m_db[0])  begin errors++; $display("FAIL rand_db_set cyc %0d: got %b want %b", n, db_set, m_db[0]); end
            checks++; if (db_reset !== m_db[1]) begin errors++; $display("FAIL rand_db_reset cyc %0d: got %b want %b", n, db_reset, m_db[1]); end
            checks++; if ((s | r) !== 1'b1)    begin errors++; $display("FAIL rand_forbidden cyc %0d: got s %b r %b want s|r=1", n, s, r); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        test_reset();
        test_clean_set();
        test_bounce();
        test_tie();
        test_overrun();
        test_mid_pulse_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
